// File: rtl/buzzer_judge.sv
// Quiz front-end: conditions buzzer/host buttons, arbitrates first buzz, runs the
// question and answer countdowns, and emits one verdict event per answer attempt.
module buzzer_judge #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned Q_TIME   = 30,
    parameter int unsigned ANS_TIME = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       btnA,
    input  logic       btnB,
    input  logic       judge_ok,
    input  logic       judge_ng,
    output logic [7:0] count,
    output logic [1:0] who,
    output logic       right,
    output logic       evt,
    output logic [1:0] state_o
);

    localparam int unsigned NIN = 5;
    localparam int unsigned TW  = $clog2(TICK_DIV);
    localparam int unsigned CW  = 8;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] Q_LOAD    = CW'(Q_TIME);
    localparam logic [CW-1:0] ANS_LOAD  = CW'(ANS_TIME);

    localparam logic [1:0] OWN_A       = 2'b01;
    localparam logic [1:0] OWN_B       = 2'b10;
    localparam logic [1:0] OWN_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ARMED  = 2'b01,
        S_LOCKED = 2'b10,
        S_REPORT = 2'b11
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [NIN-1:0]  w_raw;
    logic [NIN-1:0]  r_sync1;
    logic [NIN-1:0]  r_sync2;
    logic [NIN-1:0]  r_sync3;
    logic [NIN-1:0]  w_rise;
    logic            w_start;
    logic            w_elig_a;
    logic            w_elig_b;
    logic            w_ok;
    logic            w_ng;
    logic [TW-1:0]   r_tick_cnt;
    logic            w_tick;
    logic            w_tick_clr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nx;
    logic [CW-1:0]   r_ans_cnt;
    logic [CW-1:0]   w_ans_nx;
    logic [1:0]      r_owner;
    logic [1:0]      w_owner_nx;
    logic            r_lock_a;
    logic            w_lock_a_nx;
    logic            r_lock_b;
    logic            w_lock_b_nx;
    logic            r_prio_b;
    logic            w_prio_b_nx;
    logic [1:0]      r_who;
    logic [1:0]      w_who_nx;
    logic            r_right;
    logic            w_right_nx;
    logic            r_evt;
    logic            w_evt_nx;

    // Two-flop synchroniser plus one delay stage for rising-edge detection.
    assign w_raw = {judge_ng, judge_ok, btnB, btnA, start};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_rise   = r_sync2 & ~r_sync3;
    assign w_start  = w_rise[0];
    assign w_elig_a = w_rise[1] & ~r_lock_a;
    assign w_elig_b = w_rise[2] & ~r_lock_b;
    assign w_ok     = w_rise[3];
    assign w_ng     = w_rise[4];

    // One-second tick prescaler; restarted when a countdown phase begins.
    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick_clr || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_ans_cnt <= '0;
            r_owner   <= 2'b00;
            r_lock_a  <= 1'b0;
            r_lock_b  <= 1'b0;
            r_prio_b  <= 1'b0;
            r_who     <= 2'b00;
            r_right   <= 1'b0;
            r_evt     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_count   <= w_count_nx;
            r_ans_cnt <= w_ans_nx;
            r_owner   <= w_owner_nx;
            r_lock_a  <= w_lock_a_nx;
            r_lock_b  <= w_lock_b_nx;
            r_prio_b  <= w_prio_b_nx;
            r_who     <= w_who_nx;
            r_right   <= w_right_nx;
            r_evt     <= w_evt_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_count_nx  = r_count;
        w_ans_nx    = r_ans_cnt;
        w_owner_nx  = r_owner;
        w_lock_a_nx = r_lock_a;
        w_lock_b_nx = r_lock_b;
        w_prio_b_nx = r_prio_b;
        w_who_nx    = 2'b00;
        w_right_nx  = 1'b0;
        w_evt_nx    = 1'b0;
        w_tick_clr  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nx  = S_ARMED;
                    w_count_nx  = Q_LOAD;
                    w_lock_a_nx = 1'b0;
                    w_lock_b_nx = 1'b0;
                    w_tick_clr  = 1'b1;
                end
            end

            S_ARMED: begin
                // A buzz outranks a coincident tick, so count holds on the buzz cycle.
                if (w_elig_a || w_elig_b) begin
                    w_state_nx = S_LOCKED;
                    w_ans_nx   = ANS_LOAD;
                    w_tick_clr = 1'b1;
                    if (w_elig_a && w_elig_b) begin
                        w_owner_nx  = r_prio_b ? OWN_B : OWN_A;
                        w_prio_b_nx = ~r_prio_b;
                    end else if (w_elig_a) begin
                        w_owner_nx = OWN_A;
                    end else begin
                        w_owner_nx = OWN_B;
                    end
                end else if (w_tick) begin
                    if (r_count <= CW'(1)) begin
                        w_count_nx = '0;
                        w_owner_nx = OWN_TIMEOUT;
                        w_state_nx = S_REPORT;
                        w_who_nx   = OWN_TIMEOUT;
                        w_evt_nx   = 1'b1;
                    end else begin
                        w_count_nx = r_count - CW'(1);
                    end
                end
            end

            S_LOCKED: begin
                if (w_ng) begin
                    w_state_nx = S_REPORT;
                    w_who_nx   = r_owner;
                    w_evt_nx   = 1'b1;
                end else if (w_ok) begin
                    w_state_nx = S_REPORT;
                    w_who_nx   = r_owner;
                    w_right_nx = 1'b1;
                    w_evt_nx   = 1'b1;
                end else if (w_tick) begin
                    if (r_ans_cnt <= CW'(1)) begin
                        w_ans_nx   = '0;
                        w_state_nx = S_REPORT;
                        w_who_nx   = r_owner;
                        w_evt_nx   = 1'b1;
                    end else begin
                        w_ans_nx = r_ans_cnt - CW'(1);
                    end
                end
            end

            S_REPORT: begin
                // Wrong answers lock the owner out; question ends when nobody is left.
                if (r_right || (r_owner == OWN_TIMEOUT)) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_lock_a_nx = r_lock_a | (r_owner == OWN_A);
                    w_lock_b_nx = r_lock_b | (r_owner == OWN_B);
                    if (w_lock_a_nx && w_lock_b_nx) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_state_nx = S_ARMED;
                    end
                end
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign count   = r_count;
    assign who     = r_who;
    assign right   = r_right;
    assign evt     = r_evt;
    assign state_o = r_state;

endmodule

// File: tb/tb_buzzer_judge.sv
// Directed bench for buzzer_judge: a queue holds expected verdict events,
// each observed evt pops and checks one entry.
module tb_buzzer_judge;

    logic       clk;
    logic       rst;
    logic       start;
    logic       btnA;
    logic       btnB;
    logic       judge_ok;
    logic       judge_ng;
    logic [7:0] count;
    logic [1:0] who;
    logic       right;
    logic       evt;
    logic [1:0] state_o;

    typedef struct packed {
        logic [1:0] who;
        logic       right;
        logic [7:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   n_evt = 0;

    localparam int M_START = 1;
    localparam int M_A     = 2;
    localparam int M_B     = 4;
    localparam int M_OK    = 8;
    localparam int M_NG    = 16;

    buzzer_judge #(
        .TICK_DIV(4),
        .Q_TIME  (5),
        .ANS_TIME(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .btnA    (btnA),
        .btnB    (btnB),
        .judge_ok(judge_ok),
        .judge_ng(judge_ng),
        .count   (count),
        .who     (who),
        .right   (right),
        .evt     (evt),
        .state_o (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Advance one clock, sample 1 ns later, and score any event against the queue.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (evt === 1'b1) begin
            n_evt++;
            chk("evt_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("evt_who",   32'(who),   32'(e.who));
                chk("evt_right", 32'(right), 32'(e.right));
                chk("evt_count", 32'(count), 32'(e.count));
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Hold the selected raw inputs high 3 cycles (action lands on the 3rd), then low 3.
    task automatic press(input int m);
        start    = m[0];
        btnA     = m[1];
        btnB     = m[2];
        judge_ok = m[3];
        judge_ng = m[4];
        steps(3);
        start    = 1'b0;
        btnA     = 1'b0;
        btnB     = 1'b0;
        judge_ok = 1'b0;
        judge_ng = 1'b0;
        steps(3);
    endtask

    task automatic expect_evt(input logic [1:0] w, input logic r, input logic [7:0] c);
        exp_t e;
        e.who   = w;
        e.right = r;
        e.count = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_evt(input int max);
        int n0;
        n0 = n_evt;
        for (int i = 0; i < max && n_evt == n0; i++) step();
        chk("wait_evt", 32'(n_evt - n0), 32'd1);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        btnA     = 1'b0;
        btnB     = 1'b0;
        judge_ok = 1'b0;
        judge_ng = 1'b0;
        steps(3);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_count", 32'(count),   32'd0);
        chk("rst_who",   32'(who),     32'd0);
        chk("rst_right", 32'(right),   32'd0);
        chk("rst_evt",   32'(evt),     32'd0);
        rst = 1'b1;
        steps(2);

        // Question timeout with no buzz
        press(M_START);
        chk("s1_state_armed", 32'(state_o), 32'd1);
        chk("s1_count_load",  32'(count),   32'd5);
        step();
        chk("s1_count_tick1", 32'(count), 32'd4);
        steps(4);
        chk("s1_count_tick2", 32'(count), 32'd3);
        expect_evt(2'b11, 1'b0, 8'd0);
        wait_evt(20);
        step();
        chk("s1_state_idle", 32'(state_o), 32'd0);
        chk("s1_evt_low",    32'(evt),     32'd0);

        // A buzzes, judged correct
        press(M_START);
        press(M_A);
        chk("s2_state_locked", 32'(state_o), 32'd2);
        chk("s2_count_frozen", 32'(count),   32'd4);
        expect_evt(2'b01, 1'b1, 8'd4);
        press(M_OK);
        chk("s2_state_idle", 32'(state_o), 32'd0);
        chk("s2_count_hold", 32'(count),   32'd4);
        chk("s2_q_empty",    32'(exp_q.size()), 32'd0);

        // B wrong, B locked out, then A correct
        press(M_START);
        press(M_B);
        chk("s3_state_locked", 32'(state_o), 32'd2);
        expect_evt(2'b10, 1'b0, 8'd4);
        press(M_NG);
        chk("s3_state_rearmed", 32'(state_o), 32'd1);
        chk("s3_count_resume",  32'(count),   32'd3);
        press(M_B);
        chk("s3_lockout_state", 32'(state_o), 32'd1);
        chk("s3_lockout_count", 32'(count),   32'd2);
        press(M_A);
        chk("s3_a_locked", 32'(state_o), 32'd2);
        chk("s3_a_count",  32'(count),   32'd1);
        expect_evt(2'b01, 1'b1, 8'd1);
        press(M_OK);
        chk("s3_state_idle", 32'(state_o), 32'd0);

        // Ties alternate priority, A first
        press(M_START);
        press(M_A | M_B);
        chk("s4_tie1_locked", 32'(state_o), 32'd2);
        expect_evt(2'b01, 1'b1, 8'd4);
        press(M_OK);
        press(M_START);
        press(M_A | M_B);
        expect_evt(2'b10, 1'b1, 8'd4);
        press(M_OK);
        chk("s4_state_idle", 32'(state_o), 32'd0);
        chk("s4_q_empty",    32'(exp_q.size()), 32'd0);

        // Answer timeout for A, then B wrong leaves nobody eligible
        press(M_START);
        expect_evt(2'b01, 1'b0, 8'd4);
        press(M_A);
        wait_evt(10);
        step();
        chk("s5_rearmed",  32'(state_o), 32'd1);
        chk("s5_count",    32'(count),   32'd4);
        step();
        press(M_B);
        chk("s5_b_locked", 32'(state_o), 32'd2);
        chk("s5_b_count",  32'(count),   32'd3);
        expect_evt(2'b10, 1'b0, 8'd3);
        press(M_NG);
        chk("s5_both_locked_idle", 32'(state_o), 32'd0);

        // Asynchronous reset while locked aborts without an event
        press(M_START);
        press(M_A);
        chk("s6_locked", 32'(state_o), 32'd2);
        judge_ok = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("s6_rst_state", 32'(state_o), 32'd0);
        chk("s6_rst_count", 32'(count),   32'd0);
        chk("s6_rst_who",   32'(who),     32'd0);
        chk("s6_rst_right", 32'(right),   32'd0);
        chk("s6_rst_evt",   32'(evt),     32'd0);
        steps(3);
        rst = 1'b1;
        steps(4);
        judge_ok = 1'b0;
        steps(3);
        chk("s6_post_state", 32'(state_o), 32'd0);
        chk("s6_post_count", 32'(count),   32'd0);

        chk("total_events",  32'(n_evt),        32'd8);
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
